// File: rtl/soda_pkg.sv
// soda_pkg: definitions shared by the coin acceptor, soda FSM and total-register datapath.
// Coin type codes, coin values, default value-bus width and the coin_acceptor one-hot states.
package soda_pkg;

    // Default width of the coin value bus a_1
    localparam int SODA_VAL_W = 8;

    // Raw coin-type codes as presented by the slot sensor
    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'b00,
        COIN_DIME    = 2'b01,
        COIN_QUARTER = 2'b10,
        COIN_INVALID = 2'b11
    } coin_type_e;

    // Coin values; 5 bits hold the largest (25)
    localparam int                    COIN_VAL_W  = 5;
    localparam logic [COIN_VAL_W-1:0] VAL_NICKEL  = 5'd5;
    localparam logic [COIN_VAL_W-1:0] VAL_DIME    = 5'd10;
    localparam logic [COIN_VAL_W-1:0] VAL_QUARTER = 5'd25;

    // coin_acceptor state encodings (one-hot)
    localparam logic [4:0] CA_IDLE   = 5'b00001;
    localparam logic [4:0] CA_DEB_HI = 5'b00010;
    localparam logic [4:0] CA_ACCEPT = 5'b00100;
    localparam logic [4:0] CA_REJECT = 5'b01000;
    localparam logic [4:0] CA_HOLD   = 5'b10000;

    // Map a coin-type code to its value; the invalid code maps to zero
    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
        logic [COIN_VAL_W-1:0] v;
        case (code)
            COIN_NICKEL:  v = VAL_NICKEL;
            COIN_DIME:    v = VAL_DIME;
            COIN_QUARTER: v = VAL_QUARTER;
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: 2-flop synchroniser for the coin sensor and type code, plus a saturating
// run counter of synchronised samples that match the level the FSM is waiting for.
// stable_hi / stable_lo flag the sample that completes DEB_CYC consecutive matching samples.
module coin_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_coin,
    input  logic [1:0] i_type,
    input  logic       i_want,
    input  logic       i_clr,
    output logic       o_s_in,
    output logic [1:0] o_s_type,
    output logic       o_stable_hi,
    output logic       o_stable_lo
);

    localparam int DW = $clog2(DEB_CYC + 1);

    logic          r_in_meta;
    logic          r_in_sync;
    logic [1:0]    r_type_meta;
    logic [1:0]    r_type_sync;
    logic [DW-1:0] r_cnt;
    logic          w_at_thr;

    // Two-stage synchroniser for the asynchronous sensor inputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in_meta   <= 1'b0;
            r_in_sync   <= 1'b0;
            r_type_meta <= 2'b00;
            r_type_sync <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make both stages sample the old values on the same edge.
            r_in_meta   <= i_coin;
            r_in_sync   <= r_in_meta;
            r_type_meta <= i_type;
            r_type_sync <= r_type_meta;
        end
    end

    // Count consecutive samples at the wanted level; any other sample clears, saturate at DEB_CYC
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_in_sync == i_want) begin
            if (r_cnt != DW'(DEB_CYC))
                r_cnt <= r_cnt + DW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // The current sample is the DEB_CYC-th matching one once DEB_CYC-1 are already counted
    assign w_at_thr    = (r_cnt >= DW'(DEB_CYC - 1));
    assign o_stable_hi = r_in_sync & i_want & w_at_thr;
    assign o_stable_lo = ~r_in_sync & ~i_want & w_at_thr;
    assign o_s_in      = r_in_sync;
    assign o_s_type    = r_type_sync;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: front end of the soda machine. Debounces the coin sensor, classifies the coin,
// pulses c_1 (accepted) or reject_1 (returned) for one cycle, and holds the accepted value on a_1.
// Build option: define COIN_ACC_CNT_EN to add the coin_cnt_1 accepted-coin counter port.
module coin_acceptor
    import soda_pkg::*;
#(
    parameter int VAL_W   = SODA_VAL_W,
    parameter int DEB_CYC = 4
`ifdef COIN_ACC_CNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clk_1,
    input  logic             rst_1,
    input  logic             coin_in_1,
    input  logic [1:0]       coin_type_1,
    input  logic             inhibit_1,
    output logic             c_1,
    output logic [VAL_W-1:0] a_1,
    output logic             reject_1,
    output logic             busy_1
`ifdef COIN_ACC_CNT_EN
    ,
    output logic [CNT_W-1:0] coin_cnt_1
`endif
);

    logic [4:0]       r_state;
    logic [4:0]       w_next;
    logic [VAL_W-1:0] r_a;
    logic             w_s_in;
    logic [1:0]       w_s_type;
    logic             w_stable_hi;
    logic             w_stable_lo;
    logic             w_want;
    logic             w_clr;
    logic             w_load;

    coin_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb (
        .i_clk       (clk_1),
        .i_rst       (rst_1),
        .i_coin      (coin_in_1),
        .i_type      (coin_type_1),
        .i_want      (w_want),
        .i_clr       (w_clr),
        .o_s_in      (w_s_in),
        .o_s_type    (w_s_type),
        .o_stable_hi (w_stable_hi),
        .o_stable_lo (w_stable_lo)
    );

    // The debouncer counts highs while looking for a coin and lows while waiting for it to leave
    assign w_want = ~((r_state == CA_ACCEPT) || (r_state == CA_REJECT) || (r_state == CA_HOLD));

    // Next-state decision; the accept/reject choice is made on the sample completing the debounce
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_next = CA_IDLE;
        w_clr  = 1'b1;
        w_load = 1'b0;
        case (r_state)
            CA_IDLE: begin
                w_clr = 1'b0;
                if (w_s_in)
                    w_next = CA_DEB_HI;
            end
            CA_DEB_HI: begin
                w_clr = 1'b0;
                if (!w_s_in) begin
                    w_next = CA_IDLE;
                end else if (w_stable_hi) begin
                    if ((w_s_type != COIN_INVALID) && !inhibit_1) begin
                        w_next = CA_ACCEPT;
                        w_load = 1'b1;
                    end else begin
                        w_next = CA_REJECT;
                    end
                end else begin
                    w_next = CA_DEB_HI;
                end
            end
            CA_ACCEPT, CA_REJECT: begin
                w_next = CA_HOLD;
            end
            CA_HOLD: begin
                w_clr  = w_stable_lo;
                w_next = w_stable_lo ? CA_IDLE : CA_HOLD;
            end
            default: begin
                w_next = CA_IDLE;
            end
        endcase
    end

    // State register; an illegal encoding falls back to IDLE through the default branch
    always_ff @(posedge clk_1 or posedge rst_1) begin
        if (rst_1)
            r_state <= CA_IDLE;
        else
            r_state <= w_next;
    end

    // Coin value, loaded on the edge that enters ACCEPT and held until the next accepted coin
    always_ff @(posedge clk_1 or posedge rst_1) begin
        if (rst_1)
            r_a <= '0;
        else if (w_load)
            r_a <= VAL_W'(coin_value(w_s_type));
    end

`ifdef COIN_ACC_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Accepted-coin counter, advanced once per ACCEPT cycle and free to wrap
    always_ff @(posedge clk_1 or posedge rst_1) begin
        if (rst_1)
            r_cnt <= '0;
        else if (r_state == CA_ACCEPT)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign coin_cnt_1 = r_cnt;
`endif

    // Outputs decode exact state codes so an illegal encoding looks like IDLE
    assign c_1      = (r_state == CA_ACCEPT);
    assign reject_1 = (r_state == CA_REJECT);
    assign busy_1   = (r_state == CA_DEB_HI) || (r_state == CA_ACCEPT) ||
                      (r_state == CA_REJECT) || (r_state == CA_HOLD);
    assign a_1      = r_a;

endmodule
